voice_scheduler: RTL and testbench

- Time-multiplexed phase-accumulator sequencer for the synth voice bank. Replaces one adder per oscillator with a single shared adder.
- On each rising edge of sample_clock it walks all voices in order, one voice per clk cycle. For each voice it advances the phase accumulator and presents phase, waveform select and index to the downstream waveform/mixer datapath.
- Per-voice increment, waveform and gate are written through a simple configuration port owned by the CPU bus bridge.

---
 rtl/voice_scheduler_if.sv | 36 +++
 rtl/voice_scheduler.sv | 148 ++++++++++++++
 tb/tb_voice_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_scheduler_if.sv
// Configuration and voice-output bundle between the CPU bridge, the scheduler and the waveform datapath.
interface voice_scheduler_if #(
  parameter int unsigned NVOICES = 4,
  parameter int unsigned ACCW    = 16,
  parameter int unsigned WAVEW   = 4
);
  localparam int unsigned IDXW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  // frame trigger and config port
  logic             sample_clock;
  logic             cfg_we;
  logic [IDXW-1:0]  cfg_voice;
  logic [ACCW-1:0]  cfg_incr;
  logic [WAVEW-1:0] cfg_wave;
  logic             cfg_gate;
  logic             ovr_clr;

  // per-voice output stream and status
  logic             voice_valid;
  logic [IDXW-1:0]  voice_idx;
  logic [ACCW-1:0]  voice_phase;
  logic [WAVEW-1:0] voice_wave;
  logic             frame_done;
  logic             busy;
  logic             overrun;

  modport master (
    output sample_clock, cfg_we, cfg_voice, cfg_incr, cfg_wave, cfg_gate, ovr_clr,
    input  voice_valid, voice_idx, voice_phase, voice_wave, frame_done, busy, overrun
  );

  modport slave (
    input  sample_clock, cfg_we, cfg_voice, cfg_incr, cfg_wave, cfg_gate, ovr_clr,
    output voice_valid, voice_idx, voice_phase, voice_wave, frame_done, busy, overrun
  );
endinterface

// File: rtl/voice_scheduler.sv
// Time-multiplexed phase-accumulator sequencer: one shared adder walks every voice once per sample frame.
module voice_scheduler #(
  parameter int unsigned NVOICES = 4,
  parameter int unsigned ACCW    = 16,
  parameter int unsigned WAVEW   = 4
) (
  input logic             clk,
  input logic             rst,
  voice_scheduler_if.slave bus
);
  localparam int unsigned IDXW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NVOICES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [IDXW-1:0] cnt, cnt_nxt;
  logic            sc_q;

  logic [ACCW-1:0]    phase_mem [NVOICES];
  logic [ACCW-1:0]    incr_mem  [NVOICES];
  logic [WAVEW-1:0]   wave_mem  [NVOICES];
  logic [NVOICES-1:0] gate_mem;

  logic            start_c;
  logic            process_c;
  logic            last_c;
  logic            overrun_set_c;
  logic [ACCW-1:0] phase_nxt_c;

  // Rising-edge detect; sc_q resets high so a level already high at release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sc_q <= 1'b1;
    else     sc_q <= bus.sample_clock;
  end

  assign start_c = bus.sample_clock & ~sc_q;

  // State and voice counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: a start in IDLE launches a frame, a start in RUN is dropped and flagged
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    process_c     = 1'b0;
    last_c        = 1'b0;
    overrun_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        process_c     = 1'b1;
        last_c        = (cnt == LAST_IDX);
        overrun_set_c = start_c;
        cnt_nxt       = cnt + IDXW'(1);
        if (last_c) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Shared accumulator adder; gated-off voices collapse to zero when visited
  always_comb begin
    phase_nxt_c = '0;
    if (gate_mem[cnt]) phase_nxt_c = phase_mem[cnt] + incr_mem[cnt];
  end

  // Phase store, written only for the voice being processed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NVOICES); i++) phase_mem[i] <= '0;
    end else if (process_c) begin
      phase_mem[cnt] <= phase_nxt_c;
    end
  end

  // Config store; a same-cycle write to the active voice lands after the old values were read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NVOICES); i++) begin
        incr_mem[i] <= '0;
        wave_mem[i] <= '0;
      end
      gate_mem <= '0;
    end else if (bus.cfg_we) begin
      incr_mem[bus.cfg_voice] <= bus.cfg_incr;
      wave_mem[bus.cfg_voice] <= bus.cfg_wave;
      gate_mem[bus.cfg_voice] <= bus.cfg_gate;
    end
  end

  // Registered voice stream presented one cycle after processing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.voice_valid <= 1'b0;
      bus.voice_idx   <= '0;
      bus.voice_phase <= '0;
      bus.voice_wave  <= '0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.voice_valid <= process_c;
      bus.frame_done  <= last_c;
      if (process_c) begin
        bus.voice_idx   <= cnt;
        bus.voice_phase <= phase_nxt_c;
        bus.voice_wave  <= wave_mem[cnt];
      end else begin
        bus.voice_idx   <= '0;
        bus.voice_phase <= '0;
        bus.voice_wave  <= '0;
      end
    end
  end

  // Status flags; a new overrun beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.busy <= (state_nxt == RUN);
      if (overrun_set_c)    bus.overrun <= 1'b1;
      else if (bus.ovr_clr) bus.overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// Scenario bench for voice_scheduler with a frame-level reference model of the voice bank.
module tb_voice_scheduler;
  localparam int unsigned NV = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned WW = 4;
  localparam int unsigned IW = 2;
  localparam int MODV = 65536;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_scheduler_if #(.NVOICES(NV), .ACCW(AW), .WAVEW(WW)) bus ();

  voice_scheduler #(.NVOICES(NV), .ACCW(AW), .WAVEW(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model of the voice bank
  int m_phase [NV];
  int m_incr  [NV];
  int m_wave  [NV];
  bit m_gate  [NV];
  int got_ph  [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int v = 0; v < int'(NV); v++) begin
      m_phase[v] = 0; m_incr[v] = 0; m_wave[v] = 0; m_gate[v] = 1'b0;
    end
  endtask

  task automatic drive_idle();
    bus.cfg_we = 1'b0; bus.cfg_voice = '0; bus.cfg_incr = '0;
    bus.cfg_wave = '0; bus.cfg_gate = 1'b0; bus.ovr_clr = 1'b0;
  endtask

  task automatic do_reset(input bit sc);
    rst = 1'b1;
    bus.sample_clock = sc;
    drive_idle();
    step();
    step();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic cfg_drive(input int v, input int incr, input int wave, input bit gate);
    bus.cfg_we = 1'b1; bus.cfg_voice = IW'(v); bus.cfg_incr = AW'(incr);
    bus.cfg_wave = WW'(wave); bus.cfg_gate = gate;
  endtask

  task automatic cfg_write(input int v, input int incr, input int wave, input bit gate);
    cfg_drive(v, incr, wave, gate);
    step();
    bus.cfg_we = 1'b0;
    m_incr[v] = incr; m_wave[v] = wave; m_gate[v] = gate;
  endtask

  // Runs one frame; optionally writes config to voice wr_v in the very cycle it is processed
  task automatic run_frame(input string tag, input int wr_v, input int wr_incr,
                           input int wr_wave, input bit wr_gate);
    int exp_ph [NV];
    for (int v = 0; v < int'(NV); v++)
      exp_ph[v] = m_gate[v] ? (m_phase[v] + m_incr[v]) % MODV : 0;
    bus.sample_clock = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.voice_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b valid=%b, want busy=1 valid=0", tag, bus.busy, bus.voice_valid);
    end
    for (int v = 0; v < int'(NV); v++) begin
      if (v == wr_v) cfg_drive(wr_v, wr_incr, wr_wave, wr_gate);
      step();
      bus.cfg_we = 1'b0;
      got_ph[v] = int'(bus.voice_phase);
      checks++;
      if (bus.voice_valid !== 1'b1 || bus.voice_idx !== IW'(v) || bus.voice_wave !== WW'(m_wave[v])) begin
        errors++;
        $display("FAIL %s voice%0d: valid=%b idx=%0d wave=%0d, want 1/%0d/%0d",
                 tag, v, bus.voice_valid, bus.voice_idx, bus.voice_wave, v, m_wave[v]);
      end
      checks++;
      if (bus.voice_phase !== AW'(exp_ph[v])) begin
        errors++;
        $display("FAIL %s phase%0d: got %0d want %0d", tag, v, bus.voice_phase, exp_ph[v]);
      end
      checks++;
      if (bus.frame_done !== 1'(v == int'(NV) - 1) || bus.busy !== 1'(v < int'(NV) - 1)) begin
        errors++;
        $display("FAIL %s done/busy%0d: done=%b busy=%b, want %b/%b", tag, v,
                 bus.frame_done, bus.busy, v == int'(NV) - 1, v < int'(NV) - 1);
      end
    end
    step();
    checks++;
    if (bus.voice_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: valid=%b done=%b busy=%b, want 0/0/0", tag,
               bus.voice_valid, bus.frame_done, bus.busy);
    end
    bus.sample_clock = 1'b0;
    for (int v = 0; v < int'(NV); v++) m_phase[v] = exp_ph[v];
    if (wr_v >= 0) begin
      m_incr[wr_v] = wr_incr; m_wave[wr_v] = wr_wave; m_gate[wr_v] = wr_gate;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample_clock = 1'b1;
    drive_idle();
    model_clear();
    #2;
    checks++;
    if (bus.voice_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0 ||
        bus.frame_done !== 1'b0 || bus.voice_phase !== '0) begin
      errors++;
      $display("FAIL reset_values: valid=%b busy=%b ovr=%b done=%b phase=%0d, want all 0",
               bus.voice_valid, bus.busy, bus.overrun, bus.frame_done, bus.voice_phase);
    end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (bus.voice_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_high_sc c%0d: valid=%b busy=%b ovr=%b, want 0/0/0",
                 c, bus.voice_valid, bus.busy, bus.overrun);
      end
    end
    bus.sample_clock = 1'b0;
    step();
    run_frame("reset_first_edge", -1, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    int exp0 [6];
    exp0[0] = 12345; exp0[1] = 24690; exp0[2] = 37035;
    exp0[3] = 49380; exp0[4] = 61725; exp0[5] = 8534;
    do_reset(1'b0);
    cfg_write(0, 12345, 3, 1'b1);
    for (int v = 1; v < int'(NV); v++) cfg_write(v, int'($urandom_range(1, 65535)), int'($urandom_range(0, 15)), 1'b0);
    for (int f = 0; f < 6; f++) begin
      run_frame("wrap", -1, 0, 0, 1'b0);
      checks++;
      if (got_ph[0] != exp0[f] || got_ph[1] != 0 || got_ph[2] != 0 || got_ph[3] != 0) begin
        errors++;
        $display("FAIL wrap_f%0d: v0..3=%0d,%0d,%0d,%0d want %0d,0,0,0", f,
                 got_ph[0], got_ph[1], got_ph[2], got_ph[3], exp0[f]);
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_latency();
    int n;
    int wtab [NV];
    wtab[0] = 1; wtab[1] = 2; wtab[2] = 2; wtab[3] = 12;
    do_reset(1'b0);
    for (int v = 0; v < int'(NV); v++) cfg_write(v, v + 1, wtab[v], 1'b1);
    bus.sample_clock = 1'b1;
    n = 0;
    while (n < 10 && bus.voice_valid !== 1'b1) begin
      step();
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL latency: voice0 after %0d clk, want 2", n);
    end
    for (int v = 0; v < int'(NV); v++) begin
      if (v > 0) step();
      checks++;
      if (bus.voice_valid !== 1'b1 || bus.voice_idx !== IW'(v) ||
          bus.voice_phase !== AW'(v + 1) || bus.voice_wave !== WW'(wtab[v])) begin
        errors++;
        $display("FAIL latency_v%0d: valid=%b idx=%0d phase=%0d wave=%0d, want 1/%0d/%0d/%0d",
                 v, bus.voice_valid, bus.voice_idx, bus.voice_phase, bus.voice_wave, v, v + 1, wtab[v]);
      end
    end
    step();
    bus.sample_clock = 1'b0;
    for (int v = 0; v < int'(NV); v++) m_phase[v] = v + 1;
    step();
  endtask

  task automatic test_collision();
    run_frame("collision", 2, 100, 2, 1'b1);
    checks++;
    if (got_ph[2] != 6) begin
      errors++;
      $display("FAIL collision_same_frame: got %0d want 6", got_ph[2]);
    end
    run_frame("collision_next", -1, 0, 0, 1'b0);
    checks++;
    if (got_ph[2] != 106) begin
      errors++;
      $display("FAIL collision_next_frame: got %0d want 106", got_ph[2]);
    end
  endtask

  // Frame with a second rising edge two cycles after its start, optionally with a clear in the same cycle
  task automatic overrun_frame(input string tag, input bit clr_same);
    int exp_ph [NV];
    int extra;
    for (int v = 0; v < int'(NV); v++)
      exp_ph[v] = m_gate[v] ? (m_phase[v] + m_incr[v]) % MODV : 0;
    bus.sample_clock = 1'b1;
    step();
    bus.sample_clock = 1'b0;
    for (int v = 0; v < int'(NV); v++) begin
      if (v == 1) begin
        bus.sample_clock = 1'b1;
        bus.ovr_clr = clr_same;
      end
      step();
      bus.ovr_clr = 1'b0;
      if (v == 1) begin
        checks++;
        if (bus.overrun !== 1'b1) begin
          errors++;
          $display("FAIL %s set: overrun=%b want 1", tag, bus.overrun);
        end
      end
      checks++;
      if (bus.voice_valid !== 1'b1 || bus.voice_idx !== IW'(v) || bus.voice_phase !== AW'(exp_ph[v])) begin
        errors++;
        $display("FAIL %s voice%0d: valid=%b idx=%0d phase=%0d want 1/%0d/%0d",
                 tag, v, bus.voice_valid, bus.voice_idx, bus.voice_phase, v, exp_ph[v]);
      end
    end
    for (int v = 0; v < int'(NV); v++) m_phase[v] = exp_ph[v];
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.voice_valid === 1'b1 || bus.busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL %s after: active cycles=%0d overrun=%b, want 0 and 1", tag, extra, bus.overrun);
    end
    bus.sample_clock = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    overrun_frame("overrun", 1'b0);
    overrun_frame("overrun_clr_race", 1'b1);
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b want 0", bus.overrun);
    end
    run_frame("overrun_recover", -1, 0, 0, 1'b0);
  endtask

  task automatic test_gate_rst();
    int incr [NV];
    cfg_write(1, m_incr[1], m_wave[1], 1'b0);
    run_frame("gate_off", -1, 0, 0, 1'b0);
    checks++;
    if (got_ph[1] != 0) begin
      errors++;
      $display("FAIL gate_off_phase: got %0d want 0", got_ph[1]);
    end
    bus.sample_clock = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.voice_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.overrun !== 1'b0 || bus.voice_idx !== '0 || bus.voice_phase !== '0 || bus.voice_wave !== '0) begin
      errors++;
      $display("FAIL rst_midframe: valid=%b busy=%b done=%b ovr=%b idx=%0d phase=%0d wave=%0d, want all 0",
               bus.voice_valid, bus.busy, bus.frame_done, bus.overrun, bus.voice_idx, bus.voice_phase, bus.voice_wave);
    end
    step();
    rst = 1'b0;
    bus.sample_clock = 1'b0;
    model_clear();
    step();
    for (int v = 0; v < int'(NV); v++) begin
      incr[v] = int'($urandom_range(1, 65535));
      cfg_write(v, incr[v], int'($urandom_range(0, 15)), 1'b1);
    end
    run_frame("post_rst", -1, 0, 0, 1'b0);
    checks++;
    if (got_ph[0] != incr[0] || got_ph[1] != incr[1] || got_ph[2] != incr[2] || got_ph[3] != incr[3]) begin
      errors++;
      $display("FAIL post_rst_phases: got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
               got_ph[0], got_ph[1], got_ph[2], got_ph[3], incr[0], incr[1], incr[2], incr[3]);
    end
  endtask

  task automatic test_random();
    int nw;
    for (int f = 0; f < 25; f++) begin
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(0, NV - 1)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 3)) step();
      if ($urandom_range(0, 2) == 0)
        run_frame("random_coll", int'($urandom_range(0, NV - 1)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        run_frame("random", -1, 0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_latency();
    test_collision();
    test_overrun();
    test_gate_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
